// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: turns EX jump requests and stall levels into a PC redirect,
// per-register bubble flags for IF/ID and ID/EX, and a pipeline freeze.
//
// Request semantics: jump_en_i is a single-cycle strobe with jump_addr_i
// qualified by it; there is no back-pressure on the request. If the pipeline
// is frozen when it arrives, the request is parked (PEND) and replayed as a
// jump_en_o pulse on the first unfrozen cycle, so stall_o and jump_en_o are
// never high together.
module pipe_hold_ctrl #(
    parameter int DW           = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en_i,
    input  logic [DW-1:0] jump_addr_i,
    input  logic          stall_ex_i,
    input  logic          stall_bus_i,
    output logic          jump_en_o,
    output logic [DW-1:0] jump_addr_o,
    output logic          stall_o,
    output logic          if_id_hold_o,
    output logic          id_ex_hold_o,
    output logic          busy_o
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
        $error("pipe_hold_ctrl: FLUSH_CYCLES must be in 1..3");
    end

    // Bubbles still owed after the redirect cycle itself.
    localparam logic [1:0] CNT_INIT  = 2'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_CYC = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] pend_q, pend_d;
    logic          busy_q;

    logic          stall;
    logic          redirect;
    logic [DW-1:0] redirect_addr;
    logic          jump_en_c;
    logic [DW-1:0] jump_addr_c;
    logic          hold_c;

    assign stall = stall_ex_i | stall_bus_i;

    // Next-state, counter, parked address and raw control outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        redirect      = 1'b0;
        redirect_addr = '0;
        jump_en_c     = 1'b0;
        jump_addr_c   = '0;
        hold_c        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (jump_en_i) begin
                    if (stall) begin
                        pend_d  = jump_addr_i;
                        state_d = ST_PEND;
                    end else begin
                        redirect      = 1'b1;
                        redirect_addr = jump_addr_i;
                    end
                end
            end

            ST_FLUSH: begin
                hold_c = 1'b1;
                if (stall) begin
                    // Frozen: countdown pauses; a jump arriving now is parked.
                    if (jump_en_i) begin
                        pend_d  = jump_addr_i;
                        state_d = ST_PEND;
                    end
                end else if (jump_en_i) begin
                    redirect      = 1'b1;
                    redirect_addr = jump_addr_i;
                end else if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            ST_PEND: begin
                if (stall) begin
                    if (jump_en_i) begin
                        pend_d = jump_addr_i;
                    end
                end else begin
                    // A fresh request in the release cycle supersedes the parked one.
                    redirect      = 1'b1;
                    redirect_addr = jump_en_i ? jump_addr_i : pend_q;
                    pend_d        = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        if (redirect) begin
            jump_en_c   = 1'b1;
            jump_addr_c = redirect_addr;
            hold_c      = 1'b1;
            if (MULTI_CYC) begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_INIT;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        end
    end

    // State, countdown, parked address and the delayed busy indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= (state_q != ST_IDLE);
        end
    end

    // While reset is held only the freeze passes through.
    assign stall_o      = stall;
    assign jump_en_o    = jump_en_c & ~rst;
    assign jump_addr_o  = rst ? '0 : jump_addr_c;
    assign if_id_hold_o = hold_c & ~rst;
    assign id_ex_hold_o = hold_c & ~rst;
    assign busy_o       = busy_q;

endmodule
